// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, digit count and BCD limit.
// Used by stopwatch_ctrl and bcd_digit.
package stopwatch_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } sw_state_t;

   localparam int         DIGITS  = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   // One-cycle accepted key events, bit order matches {lap, clear, start}
   typedef struct packed {
      logic lap;
      logic clear;
      logic start;
   } sw_keys_t;
endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch counter: wraps 9->0 on enable and carries
// into the next decade in the same cycle.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       carry
);
   logic [3:0] r_digit;

   assign digit = r_digit;
   assign carry = en && (r_digit == BCD_MAX);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         r_digit <= '0;
      else if (clr)
         r_digit <= '0;
      else if (en)
         r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
   end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch: key synchronizers, prescaler, start/pause/clear FSM.
// Define STOPWATCH_LAP_EN to build the LAP state, lap snapshot and key_lap path.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 500000
)(
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        key_start,
   input  logic        key_clear,
   input  logic        key_lap,
   output logic [15:0] disp,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);
   localparam int PW = $clog2(TICK_DIV);

   sw_state_t              r_state;
   logic                   r_running;
   logic [2:0]             w_key_raw, r_s1, r_s2, r_s3, r_arm;
   logic [1:0]             r_vld;
   sw_keys_t               r_evt;
   logic [PW-1:0]          r_presc;
   logic                   r_ovf;
   logic                   w_active, w_tick, w_to_idle;
   logic [DIGITS:0]        w_en;
   logic [DIGITS-1:0][3:0] w_digit;
   logic [15:0]            w_count;

`ifdef STOPWATCH_LAP_EN
   logic        r_lap;
   logic [15:0] r_snap;
   logic        w_lap_acc;
   assign w_key_raw = {key_lap, key_clear, key_start};
`else
   logic w_unused_lap;
   assign w_unused_lap = key_lap | r_evt.lap;
   assign w_key_raw    = {1'b0, key_clear, key_start};
`endif

   // A key only arms once it has been seen low after reset, so a key held
   // through reset release never produces an event.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_s1  <= '0;
         r_s2  <= '0;
         r_s3  <= '0;
         r_arm <= '0;
         r_vld <= '0;
         r_evt <= '0;
      end else begin
         r_s1  <= w_key_raw;
         r_s2  <= r_s1;
         r_s3  <= r_s2;
         r_vld <= {r_vld[0], 1'b1};
         if (r_vld[1])
            r_arm <= r_arm | ~r_s2;
         r_evt <= sw_keys_t'(r_s2 & ~r_s3 & r_arm);
      end
   end

   assign w_active  = (r_state == RUN) || (r_state == LAP);
   assign w_tick    = w_active && (r_presc == PW'(TICK_DIV - 1));
   assign w_to_idle = (r_state == PAUSE) && r_evt.clear;

   assign w_en[0] = w_tick;
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
         .CLOCK_50 (CLOCK_50),
         .reset    (reset),
         .en       (w_en[i]),
         .clr      (w_to_idle),
         .digit    (w_digit[i]),
         .carry    (w_en[i+1])
      );
   end
   assign w_count = w_digit;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
         r_ovf   <= 1'b0;
      end else if (w_to_idle) begin
         r_presc <= '0;
         r_ovf   <= 1'b0;
      end else if (w_active) begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_en[DIGITS])
            r_ovf <= 1'b1;
      end
   end

   // Each case arm takes the highest-priority event that is legal in that state.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         r_lap     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE:
               if (r_evt.start) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            RUN:
               if (r_evt.start) begin
                  r_state   <= PAUSE;
                  r_running <= 1'b0;
               end
`ifdef STOPWATCH_LAP_EN
               else if (r_evt.lap) begin
                  r_state <= LAP;
                  r_lap   <= 1'b1;
               end
`endif
            PAUSE:
               if (r_evt.clear) begin
                  r_state <= IDLE;
               end else if (r_evt.start) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
`ifdef STOPWATCH_LAP_EN
            LAP:
               if (r_evt.lap) begin
                  r_state <= RUN;
                  r_lap   <= 1'b0;
               end
`endif
            default: begin
               r_state   <= IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

`ifdef STOPWATCH_LAP_EN
   assign w_lap_acc = (r_state == RUN) && r_evt.lap && !r_evt.start;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         r_snap <= '0;
      else if (w_lap_acc)
         r_snap <= w_count;
   end

   assign disp       = (r_state == LAP) ? r_snap : w_count;
   assign lap_active = r_lap;
`else
   assign disp       = w_count;
   assign lap_active = 1'b0;
`endif

   assign running  = r_running;
   assign overflow = r_ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch bench: directed scenarios plus random key traffic, all checked
// every cycle against a decimal-count reference model.
module tb_stopwatch_ctrl;
   localparam int TD = 4;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b0;
   logic        key_start = 1'b0, key_clear = 1'b0, key_lap = 1'b0;
   logic [15:0] disp;
   logic        running, lap_active, overflow;

   int n_chk = 0;
   int n_err = 0;

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .key_start  (key_start),
      .key_clear  (key_clear),
      .key_lap    (key_lap),
      .disp       (disp),
      .running    (running),
      .lap_active (lap_active),
      .overflow   (overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // Reference model: count kept as a plain integer 0..9999, events derived
   // from the sampled key history (rise between two post-reset samples,
   // acted on three edges after the first high sample).
   typedef enum {S_IDLE, S_RUN, S_PAUSE, S_LAP} ms_t;
   ms_t      m_st;
   int       m_cnt, m_presc, m_snap, m_nsamp;
   bit       m_ovf;
   bit [3:0] h_s, h_c, h_l;

   always @(posedge CLOCK_50 or negedge reset) begin : model
      bit es, ec, el, act, tk;
      ms_t nst;
      if (!reset) begin
         m_st = S_IDLE; m_cnt = 0; m_presc = 0; m_snap = 0; m_ovf = 0;
         m_nsamp = 0; h_s = '0; h_c = '0; h_l = '0;
      end else begin
         es  = (m_nsamp >= 4) && h_s[2] && !h_s[3];
         ec  = (m_nsamp >= 4) && h_c[2] && !h_c[3];
         el  = LAP_EN && (m_nsamp >= 4) && h_l[2] && !h_l[3];
         act = (m_st == S_RUN) || (m_st == S_LAP);
         tk  = act && (m_presc == TD - 1);
         nst = m_st;
         case (m_st)
            S_IDLE:  if (es) nst = S_RUN;
            S_RUN:   if (es) nst = S_PAUSE;
                     else if (el) begin nst = S_LAP; m_snap = m_cnt; end
            S_PAUSE: if (ec) nst = S_IDLE; else if (es) nst = S_RUN;
            S_LAP:   if (el) nst = S_RUN;
            default: nst = S_IDLE;
         endcase
         if (act) begin
            if (tk) begin
               m_presc = 0;
               m_cnt   = (m_cnt + 1) % 10000;
               if (m_cnt == 0) m_ovf = 1;
            end else
               m_presc++;
         end
         if (nst == S_IDLE && m_st != S_IDLE) begin
            m_cnt = 0; m_presc = 0; m_ovf = 0;
         end
         m_st = nst;
         h_s = {h_s[2:0], key_start};
         h_c = {h_c[2:0], key_clear};
         h_l = {h_l[2:0], key_lap};
         m_nsamp++;
      end
   end

   always @(negedge CLOCK_50) begin
      if (reset) begin
         chk("m_disp", 32'(disp), 32'(bcd(m_st == S_LAP ? m_snap : m_cnt)));
         chk("m_running", 32'(running), 32'(m_st == S_RUN || m_st == S_LAP));
         chk("m_lap", 32'(lap_active), 32'(m_st == S_LAP));
         chk("m_ovf", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // Keys high for exactly one sampling edge
   task automatic pulse(input bit s, input bit c, input bit l);
      key_start = s; key_clear = c; key_lap = l;
      step(1);
      key_start = 0; key_clear = 0; key_lap = 0;
   endtask

   initial begin
      step(3);
      chk("rst_disp", 32'(disp), 32'h0);
      chk("rst_running", 32'(running), 32'h0);
      chk("rst_lap", 32'(lap_active), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      reset = 1;
      step(4);

      // start latency and first counts
      pulse(1, 0, 0);
      step(2); chk("start_n2", 32'(running), 32'h0);
      step(1); chk("start_n3", 32'(running), 32'h1);
      chk("run_disp0", 32'(disp), 32'h0);
      step(4); chk("first_tick", 32'(disp), 32'h0001);
      step(36); chk("run_40", 32'(disp), 32'h0010);
      pulse(1, 0, 0); step(4);
      pulse(0, 1, 0); step(4);
      chk("clr_disp", 32'(disp), 32'h0);
      chk("clr_running", 32'(running), 32'h0);

      // lap freeze (or ignored lap without the feature)
      pulse(1, 0, 0); step(20);
      pulse(0, 0, 1); step(3);
      chk("lap_enter", 32'(lap_active), 32'(LAP_EN));
      chk("lap_disp", 32'(disp), 32'h0005);
      for (int i = 1; i <= 36; i++) begin
         step(1);
         chk("lap_hold", 32'(disp), 32'(LAP_EN ? 16'h0005 : bcd((21 + i) / 4)));
      end
      pulse(0, 0, 1); step(3);
      chk("lap_exit", 32'(lap_active), 32'h0);
      chk("lap_live", 32'(disp), 32'h0015);
      chk("lap_running", 32'(running), 32'h1);

      // simultaneous events: RUN -> PAUSE, PAUSE -> IDLE
      pulse(1, 1, 1); step(3);
      chk("sim_run_st", 32'(running), 32'h0);
      chk("sim_run_disp", 32'(disp), 32'h0016);
      step(2);
      pulse(1, 1, 1); step(3);
      chk("sim_pause_disp", 32'(disp), 32'h0);
      chk("sim_pause_run", 32'(running), 32'h0);
      step(5);
      chk("sim_idle_hold", 32'(disp), 32'h0);

      // 9999 -> 0000 wrap
      pulse(1, 0, 0); step(40000);
      chk("pre_wrap", 32'(disp), 32'h9999);
      chk("pre_wrap_ovf", 32'(overflow), 32'h0);
      step(3);
      chk("wrap_disp", 32'(disp), 32'h0);
      chk("wrap_ovf", 32'(overflow), 32'h1);
      chk("wrap_run", 32'(running), 32'h1);
      pulse(1, 0, 0); step(4);
      pulse(0, 1, 0); step(3);
      chk("ovf_clr_disp", 32'(disp), 32'h0);
      chk("ovf_clr", 32'(overflow), 32'h0);
      chk("ovf_clr_idle", 32'(running), 32'h0);

      // reset mid-run with start held through release
      pulse(1, 0, 0); step(171);
      chk("pre_rst", 32'(disp), 32'h0042);
      key_start = 1;
      #2 reset = 0;
      #1 chk("async_disp", 32'(disp), 32'h0);
      chk("async_run", 32'(running), 32'h0);
      step(3);
      reset = 1;
      step(20);
      chk("held_idle", 32'(running), 32'h0);
      chk("held_disp", 32'(disp), 32'h0);
      key_start = 0; step(2);
      pulse(1, 0, 0); step(3);
      chk("fresh_start", 32'(running), 32'h1);

      // random key traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         key_start = ($urandom_range(0, 9) == 0);
         key_clear = ($urandom_range(0, 9) == 0);
         key_lap   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 0;
            step(2);
            reset = 1;
         end else
            step(1);
      end
      key_start = 0; key_clear = 0; key_lap = 0;
      step(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
